// File: rtl/oc8051_ecall_ctrl.sv
// oc8051_ecall_ctrl -- ECALL/ERET program-flow controller.
// Captures the handler target and the return address on ECALL and requests a PC
// load toward the handler. On ERET it requests a PC load back to the saved
// return address. The saved return address is readable as two SFR bytes.
// Optional feature macro: OC8051_ECALL_NEST_EN. When it is defined, the design
// keeps a two-entry return-address stack so one nested ECALL is allowed.
//
// state  | meaning
// IDLE   | not inside a handler, no load pending
// ENTER  | pc_load toward tgt, waiting for pc_ack
// ACTIVE | executing inside a handler
// EXIT   | pc_load toward top-of-stack era, waiting for pc_ack

module oc8051_ecall_ctrl #(
    parameter logic [7:0] OC8051_SFR_ERA_LO = 8'hb6,
    parameter logic [7:0] OC8051_SFR_ERA_HI = 8'hb7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] etr,
    input  logic        ecall_req,
    input  logic        eret_req,
    input  logic [15:0] ret_pc,
    input  logic        pc_ack,
    input  logic [7:0]  rd_addr,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic        in_ecall,
    output logic        ecall_fault,
    output logic [7:0]  sfr_data,
    output logic        sfr_hit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2,
        EXIT   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  depth;
    logic [15:0] tgt;
    logic [15:0] era0;
    logic [15:0] era_top;
    logic        fault_nxt;
    logic        load_tgt;
    logic        push0;
    logic        pop;
`ifdef OC8051_ECALL_NEST_EN
    logic [15:0] era1;
    logic        push1;
`endif

    // State register and registered fault pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ecall_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            ecall_fault <= fault_nxt;
        end
    end

    // Next-state decode; a request that cannot be honoured raises a fault.
    always_comb begin
        state_nxt = state;
        fault_nxt = 1'b0;
        load_tgt  = 1'b0;
        push0     = 1'b0;
        pop       = 1'b0;
`ifdef OC8051_ECALL_NEST_EN
        push1     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ecall_req) begin
                    if (etr != 16'h0000) begin
                        load_tgt  = 1'b1;
                        push0     = 1'b1;
                        state_nxt = ENTER;
                    end else begin
                        fault_nxt = 1'b1;
                    end
                end else if (eret_req) begin
                    fault_nxt = 1'b1;
                end
            end
            ENTER: begin
                if (ecall_req || eret_req) begin
                    fault_nxt = 1'b1;
                end
                if (pc_ack) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (eret_req) begin
                    state_nxt = EXIT;
                end else if (ecall_req) begin
`ifdef OC8051_ECALL_NEST_EN
                    if ((depth == 2'd1) && (etr != 16'h0000)) begin
                        load_tgt  = 1'b1;
                        push1     = 1'b1;
                        state_nxt = ENTER;
                    end else begin
                        fault_nxt = 1'b1;
                    end
`else
                    fault_nxt = 1'b1;
`endif
                end
            end
            EXIT: begin
                if (ecall_req || eret_req) begin
                    fault_nxt = 1'b1;
                end
                if (pc_ack) begin
                    pop       = 1'b1;
                    state_nxt = (depth <= 2'd1) ? IDLE : ACTIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Target, return-address stack and stack depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt   <= 16'h0000;
            era0  <= 16'h0000;
            depth <= 2'd0;
`ifdef OC8051_ECALL_NEST_EN
            era1  <= 16'h0000;
`endif
        end else begin
            if (load_tgt) begin
                tgt <= etr;
            end
            if (push0) begin
                era0  <= ret_pc;
                depth <= 2'd1;
`ifdef OC8051_ECALL_NEST_EN
            end else if (push1) begin
                era1  <= ret_pc;
                depth <= 2'd2;
`endif
            end else if (pop) begin
                depth <= depth - 2'd1;
            end
        end
    end

    // Top-of-stack select: the nested entry only exists when nesting is built in.
    always_comb begin
`ifdef OC8051_ECALL_NEST_EN
        era_top = (depth == 2'd2) ? era1 : era0;
`else
        era_top = era0;
`endif
    end

    // PC load request and handler flag follow the state directly so that reset clears them at once.
    always_comb begin
        pc_load  = 1'b0;
        pc_new   = 16'h0000;
        in_ecall = 1'b0;
        case (state)
            ENTER: begin
                pc_load  = 1'b1;
                pc_new   = tgt;
                in_ecall = (depth == 2'd2);
            end
            ACTIVE: begin
                in_ecall = 1'b1;
            end
            EXIT: begin
                pc_load  = 1'b1;
                pc_new   = era_top;
                in_ecall = 1'b1;
            end
            default: begin
                pc_load  = 1'b0;
            end
        endcase
    end

    // SFR read port for the saved return address.
    always_comb begin
        sfr_hit  = 1'b0;
        sfr_data = 8'h00;
        if (rd_addr == OC8051_SFR_ERA_LO) begin
            sfr_hit  = 1'b1;
            sfr_data = era_top[7:0];
        end else if (rd_addr == OC8051_SFR_ERA_HI) begin
            sfr_hit  = 1'b1;
            sfr_data = era_top[15:8];
        end
    end

endmodule

// File: tb/tb_oc8051_ecall_ctrl.sv
// Bench for oc8051_ecall_ctrl: table of per-cycle vectors plus hand sequences
// for nesting and reset. Works with or without OC8051_ECALL_NEST_EN.

module tb_oc8051_ecall_ctrl;

    localparam logic [7:0] LO = 8'hb6;
    localparam logic [7:0] HI = 8'hb7;

    logic        clk;
    logic        rst;
    logic [15:0] etr;
    logic        ecall_req;
    logic        eret_req;
    logic [15:0] ret_pc;
    logic        pc_ack;
    logic [7:0]  rd_addr;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        in_ecall;
    logic        ecall_fault;
    logic [7:0]  sfr_data;
    logic        sfr_hit;

    typedef struct {
        logic        ec;
        logic        er;
        logic        ack;
        logic [15:0] etr;
        logic [15:0] ret;
        logic [7:0]  rd;
        logic        ld;
        logic [15:0] pc;
        logic        inh;
        logic        flt;
        logic        hit;
        logic [7:0]  dat;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    oc8051_ecall_ctrl #(
        .OC8051_SFR_ERA_LO(LO),
        .OC8051_SFR_ERA_HI(HI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .etr        (etr),
        .ecall_req  (ecall_req),
        .eret_req   (eret_req),
        .ret_pc     (ret_pc),
        .pc_ack     (pc_ack),
        .rd_addr    (rd_addr),
        .pc_load    (pc_load),
        .pc_new     (pc_new),
        .in_ecall   (in_ecall),
        .ecall_fault(ecall_fault),
        .sfr_data   (sfr_data),
        .sfr_hit    (sfr_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ec, input logic er, input logic ack,
                                input logic [15:0] e, input logic [15:0] r, input logic [7:0] rd,
                                input logic ld, input logic [15:0] pc, input logic inh,
                                input logic flt, input logic hit, input logic [7:0] dat);
        vec_t v;
        v.ec = ec; v.er = er; v.ack = ack; v.etr = e; v.ret = r; v.rd = rd;
        v.ld = ld; v.pc = pc; v.inh = inh; v.flt = flt; v.hit = hit; v.dat = dat;
        return v;
    endfunction

    task automatic chk(input string nm, input string tag, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s got %h want %h", tag, nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk("pc_load",     tag, {15'd0, pc_load},     {15'd0, v.ld});
        chk("pc_new",      tag, pc_new,               v.pc);
        chk("in_ecall",    tag, {15'd0, in_ecall},    {15'd0, v.inh});
        chk("ecall_fault", tag, {15'd0, ecall_fault}, {15'd0, v.flt});
        chk("sfr_hit",     tag, {15'd0, sfr_hit},     {15'd0, v.hit});
        chk("sfr_data",    tag, {8'd0, sfr_data},     {8'd0, v.dat});
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        ecall_req = v.ec;
        eret_req  = v.er;
        pc_ack    = v.ack;
        etr       = v.etr;
        ret_pc    = v.ret;
        rd_addr   = v.rd;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk_outs(tag, e);
        end
    endtask

    task automatic idle_inputs();
        ecall_req = 1'b0;
        eret_req  = 1'b0;
        pc_ack    = 1'b0;
        etr       = 16'h0000;
        ret_pc    = 16'h0000;
        rd_addr   = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        z = mk(0,0,0,16'h0,16'h0,8'h00, 0,16'h0,0,0,0,8'h00);

        //       ec er ack etr       ret       rd   | ld pc        in f  hit dat
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,16'h1200,16'h0045,LO,    1,16'h1200,0,0,1,8'h45));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,HI,    1,16'h1200,0,0,1,8'h00));
        tbl.push_back(mk(0,0,1,16'h0000,16'h0000,LO,    0,16'h0000,1,0,1,8'h45));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,HI,    0,16'h0000,1,0,1,8'h00));
        tbl.push_back(mk(0,1,0,16'h0000,16'h0000,8'h00, 1,16'h0045,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,8'h00, 1,16'h0045,1,0,0,8'h00));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,8'h00, 1,16'h0045,1,0,0,8'h00));
        tbl.push_back(mk(0,0,1,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));
        tbl.push_back(mk(0,0,1,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));
        tbl.push_back(mk(1,0,0,16'h0000,16'h0777,8'h00, 0,16'h0000,0,1,0,8'h00));
        tbl.push_back(mk(0,0,0,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));
        tbl.push_back(mk(0,1,0,16'h0000,16'h0000,8'h00, 0,16'h0000,0,1,0,8'h00));
        tbl.push_back(mk(1,1,0,16'h2222,16'h0abc,LO,    1,16'h2222,0,0,1,8'hbc));
        tbl.push_back(mk(1,0,0,16'h5555,16'h1111,HI,    1,16'h2222,0,1,1,8'h0a));
        tbl.push_back(mk(0,1,1,16'h0000,16'h0000,8'h00, 0,16'h0000,1,1,0,8'h00));
        tbl.push_back(mk(1,1,0,16'h3333,16'h4444,LO,    1,16'h0abc,1,0,1,8'hbc));
        tbl.push_back(mk(0,1,0,16'h0000,16'h0000,8'h00, 1,16'h0abc,1,1,0,8'h00));
        tbl.push_back(mk(0,0,1,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));

        idle_inputs();
        rst = 1'b0;
        #23;
        chk_outs("reset_state", z);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Second ECALL while inside a handler.
        run_vec("nest_a", mk(1,0,0,16'h1200,16'h0045,8'h00, 1,16'h1200,0,0,0,8'h00));
        run_vec("nest_b", mk(0,0,1,16'h0000,16'h0000,8'h00, 0,16'h0000,1,0,0,8'h00));
`ifdef OC8051_ECALL_NEST_EN
        run_vec("nest_c", mk(1,0,0,16'h3400,16'h1210,LO,    1,16'h3400,1,0,1,8'h10));
        run_vec("nest_d", mk(0,0,1,16'h0000,16'h0000,HI,    0,16'h0000,1,0,1,8'h12));
        run_vec("nest_e", mk(1,0,0,16'h5000,16'h7777,8'h00, 0,16'h0000,1,1,0,8'h00));
        run_vec("nest_f", mk(0,1,0,16'h0000,16'h0000,LO,    1,16'h1210,1,0,1,8'h10));
        run_vec("nest_g", mk(0,0,1,16'h0000,16'h0000,LO,    0,16'h0000,1,0,1,8'h45));
        run_vec("nest_h", mk(0,1,0,16'h0000,16'h0000,8'h00, 1,16'h0045,1,0,0,8'h00));
        run_vec("nest_i", mk(0,0,1,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));
`else
        run_vec("nest_c", mk(1,0,0,16'h3400,16'h1210,LO,    0,16'h0000,1,1,1,8'h45));
        run_vec("nest_d", mk(0,1,0,16'h0000,16'h0000,8'h00, 1,16'h0045,1,0,0,8'h00));
        run_vec("nest_e", mk(0,0,1,16'h0000,16'h0000,8'h00, 0,16'h0000,0,0,0,8'h00));
`endif

        // Reset in the middle of ENTER with no acknowledge.
        run_vec("rst_a", mk(1,0,0,16'h1200,16'h0045,8'h00, 1,16'h1200,0,0,0,8'h00));
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        chk_outs("rst_mid_enter", z);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("rst_after%0d", i),
                    mk(0,0,(i == 1),16'h0000,16'h0000,LO, 0,16'h0000,0,0,1,8'h00));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oc8051_ecall_ctrl.md
OC8051_ECALL_CTRL -- requirements
Module: oc8051_ecall_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port etr  input  16  ecall target, from the ecall target register SFR block.
REQ-004 SHALL have port ecall_req  input  1  single-cycle pulse; ECALL instruction decoded.
REQ-005 SHALL have port eret_req  input  1  single-cycle pulse; ERET instruction decoded.
REQ-006 SHALL have port ret_pc  input  16  address of the instruction following ECALL.
REQ-007 SHALL have port pc_ack  input  1  PC unit accepted pc_new this cycle.
REQ-008 SHALL have port rd_addr  input  8  SFR read address.
REQ-009 SHALL have port pc_load  output  1  request to load pc_new into PC.
REQ-010 SHALL have port pc_new  output  16  PC load value.
REQ-011 SHALL have port in_ecall  output  1  core is executing inside an ecall handler.
REQ-012 SHALL have port ecall_fault  output  1  one-cycle pulse on an illegal request.
REQ-013 SHALL have port sfr_data  output  8  saved return address byte.
REQ-014 SHALL have port sfr_hit  output  1  rd_addr matches OC8051_SFR_ERA_LO or OC8051_SFR_ERA_HI.

Function
REQ-015 SHALL implement FSM states IDLE, ENTER, ACTIVE, EXIT.
REQ-016 IDLE, ecall_req with etr!=16'h0000: SHALL latch tgt<=etr, era<=ret_pc, depth<=1, go ENTER.
REQ-017 IDLE, ecall_req with etr==16'h0000: SHALL pulse ecall_fault, stay IDLE, registers unchanged.
REQ-018 IDLE, eret_req alone: SHALL pulse ecall_fault; ecall_req+eret_req same cycle: ecall wins, eret ignored, no fault.
REQ-019 ENTER: SHALL drive pc_load=1, pc_new=tgt; hold both stable until pc_ack; on pc_ack go ACTIVE.
REQ-020 ACTIVE, eret_req: SHALL go EXIT; eret takes priority over a simultaneous ecall_req, which is ignored without fault.
REQ-021 EXIT: SHALL drive pc_load=1, pc_new=top-of-stack era; on pc_ack pop; depth 0 -> IDLE, else ACTIVE.
REQ-022 ecall_req or eret_req in ENTER or EXIT: SHALL be ignored and SHALL pulse ecall_fault.
REQ-023 pc_load SHALL assert exactly one cycle after the accepting request; pc_load=0, pc_new=0 outside ENTER/EXIT.
REQ-024 in_ecall SHALL be 1 in ENTER-complete (ACTIVE), EXIT and nested ENTER; 0 in IDLE and first ENTER.
REQ-025 ecall_fault SHALL be registered, high exactly one cycle after the offending request.
REQ-026 sfr_hit/sfr_data SHALL be combinational: ERA_LO -> era[7:0], ERA_HI -> era[15:8] of top of stack; otherwise 0.
REQ-027 pc_ack outside ENTER/EXIT SHALL be ignored.

Reset
REQ-028 rst low SHALL immediately force IDLE, depth=0, tgt=era(all entries)=0, pc_load=0, pc_new=0, in_ecall=0, ecall_fault=0.
REQ-029 Reset asserted mid-ENTER/EXIT SHALL abandon the load; no pc_load after release until a new request.

Configuration
REQ-030 Macro OC8051_ECALL_NEST_EN defined: SHALL provide a 2-entry era stack; ecall_req in ACTIVE at depth 1 with etr!=0 pushes ret_pc, depth=2, goes ENTER; at depth 2 SHALL fault.
REQ-031 Macro OC8051_ECALL_NEST_EN undefined: SHALL keep a single era register; any ecall_req in ACTIVE SHALL fault and be ignored.

Verification
REQ-032 etr=16'h1200, ecall_req with ret_pc=16'h0045 -> next cycle pc_load=1, pc_new=16'h1200; pc_ack -> ACTIVE, in_ecall=1; rd_addr=ERA_HI -> sfr_data=8'h00, ERA_LO -> 8'h45.
REQ-033 From ACTIVE, eret_req, pc_ack delayed 3 cycles -> pc_load=1, pc_new=16'h0045 held 3 cycles; after ack in_ecall=0, IDLE.
REQ-034 etr=16'h0000, ecall_req -> ecall_fault one cycle, pc_load stays 0; eret_req in IDLE -> ecall_fault one cycle.
REQ-035 With OC8051_ECALL_NEST_EN: ecall(ret 0x0045), ack, ecall(ret 0x1210), ack, eret -> pc_new=0x1210, in_ecall=1; eret -> pc_new=0x0045, in_ecall=0; third nested ecall -> fault. Without macro: second ecall -> fault.
REQ-036 rst low during ENTER with pc_ack never given -> pc_load=0 immediately, all outputs 0; after release no pc_load.
